// File: rtl/immediate_gen_stage.sv
// immediate_gen_stage: RISC-V immediate decode with a 2-entry elastic output (output reg + skid reg).
// Ports: clk/reset (sync, active-low); valid_i/ready_o/op_i/Instruction_bus_i in;
// valid_o/ready_i/Immediate_o/fmt_o/illegal_o out; illegal_cnt_o saturating illegal-opcode count.
module immediate_gen_stage #(
  parameter int XLEN        = 32,
  parameter bit ZERO_EXT_SB = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [6:0]      op_i,
  input  logic [31:0]     Instruction_bus_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] Immediate_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic [7:0]      illegal_cnt_o
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state;
  logic [XLEN-1:0] imm_d, skid_imm, i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [2:0] fmt_d, skid_fmt;
  logic [11:0] s12;
  logic [12:0] b13;
  logic take_in, take_out, unused_op_bits;
  assign unused_op_bits = ^Instruction_bus_i[6:0];
  assign ready_o  = state != TWO;
  assign valid_o  = state != EMPTY;
  assign take_in  = valid_i && ready_o;
  assign take_out = valid_o && ready_i;
  always_comb begin
    fmt_d = op_i == 7'h33 ? 3'd0 :
            (op_i == 7'h13 || op_i == 7'h03 || op_i == 7'h67 || op_i == 7'h73) ? 3'd1 :
            op_i == 7'h23 ? 3'd2 :
            op_i == 7'h63 ? 3'd3 :
            (op_i == 7'h37 || op_i == 7'h17) ? 3'd4 :
            op_i == 7'h6F ? 3'd5 : 3'd7;
    s12   = {Instruction_bus_i[31:25], Instruction_bus_i[11:7]};
    b13   = {Instruction_bus_i[31], Instruction_bus_i[7], Instruction_bus_i[30:25], Instruction_bus_i[11:8], 1'b0};
    i_imm = XLEN'($signed(Instruction_bus_i[31:20]));
    s_imm = ZERO_EXT_SB ? XLEN'(s12) : XLEN'($signed(s12));
    b_imm = ZERO_EXT_SB ? XLEN'(b13) : XLEN'($signed(b13));
    u_imm = XLEN'($signed({Instruction_bus_i[31:12], 12'b0}));
    j_imm = XLEN'($signed({Instruction_bus_i[31], Instruction_bus_i[19:12], Instruction_bus_i[20], Instruction_bus_i[30:21], 1'b0}));
    imm_d = fmt_d == 3'd1 ? i_imm :
            fmt_d == 3'd2 ? s_imm :
            fmt_d == 3'd3 ? b_imm :
            fmt_d == 3'd4 ? u_imm :
            fmt_d == 3'd5 ? j_imm : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= EMPTY;
      Immediate_o   <= '0;
      fmt_o         <= '0;
      illegal_o     <= 1'b0;
      illegal_cnt_o <= '0;
      skid_imm      <= '0;
      skid_fmt      <= '0;
    end else begin
      if (take_in && fmt_d == 3'd7 && illegal_cnt_o != 8'hFF)
        illegal_cnt_o <= illegal_cnt_o + 8'd1;
      case (state)
        EMPTY: if (take_in) begin
          Immediate_o <= imm_d;
          fmt_o       <= fmt_d;
          illegal_o   <= fmt_d == 3'd7;
          state       <= ONE;
        end
        ONE: if (take_in && !take_out) begin
          skid_imm <= imm_d;
          skid_fmt <= fmt_d;
          state    <= TWO;
        end else if (take_in) begin
          Immediate_o <= imm_d;
          fmt_o       <= fmt_d;
          illegal_o   <= fmt_d == 3'd7;
        end else if (take_out) begin
          state <= EMPTY;
        end
        TWO: if (take_out) begin
          Immediate_o <= skid_imm;
          fmt_o       <= skid_fmt;
          illegal_o   <= skid_fmt == 3'd7;
          state       <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_immediate_gen_stage.sv
// tb_immediate_gen_stage: directed vector bench for immediate_gen_stage (default, zero-ext and 64-bit variants).
module tb_immediate_gen_stage;
  logic clk = 0, reset = 0, valid_i = 0, ready_i = 1;
  logic [6:0] op_i = '0;
  logic [31:0] inst = '0;
  logic ready_o, valid_o, illegal_o;
  logic [31:0] imm;
  logic [2:0] fmt_o;
  logic [7:0] cnt;
  logic z_ready, z_valid, z_ill, w_ready, w_valid, w_ill;
  logic [31:0] z_imm;
  logic [63:0] w_imm;
  logic [2:0] z_fmt, w_fmt;
  logic [7:0] z_cnt, w_cnt;
  int n_cmp = 0, n_err = 0, exp_cnt = 0;

  immediate_gen_stage dut (.clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .Instruction_bus_i(inst), .valid_o(valid_o), .ready_i(ready_i), .Immediate_o(imm), .fmt_o(fmt_o),
    .illegal_o(illegal_o), .illegal_cnt_o(cnt));
  immediate_gen_stage #(.ZERO_EXT_SB(1'b1)) dut_z (.clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(z_ready),
    .op_i(op_i), .Instruction_bus_i(inst), .valid_o(z_valid), .ready_i(ready_i), .Immediate_o(z_imm),
    .fmt_o(z_fmt), .illegal_o(z_ill), .illegal_cnt_o(z_cnt));
  immediate_gen_stage #(.XLEN(64)) dut_w (.clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(w_ready),
    .op_i(op_i), .Instruction_bus_i(inst), .valid_o(w_valid), .ready_i(ready_i), .Immediate_o(w_imm),
    .fmt_o(w_fmt), .illegal_o(w_ill), .illegal_cnt_o(w_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [6:0] op, input logic [31:0] ins);
    valid_i = 1; op_i = op; inst = ins;
    @(posedge clk); @(negedge clk);
    valid_i = 0;
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [31:0] ins;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{7'h13, 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
    tbl[1]  = '{7'h23, 32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0};
    tbl[2]  = '{7'h63, 32'hFE000C63, 32'hFFFFF7F8, 3'd3, 1'b0};
    tbl[3]  = '{7'h63, 32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
    tbl[4]  = '{7'h37, 32'h123450B7, 32'h12345000, 3'd4, 1'b0};
    tbl[5]  = '{7'h17, 32'h80000097, 32'h80000000, 3'd4, 1'b0};
    tbl[6]  = '{7'h6F, 32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0};
    tbl[7]  = '{7'h33, 32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b0};
    tbl[8]  = '{7'h7F, 32'hFFFFFFFF, 32'h00000000, 3'd7, 1'b1};
    tbl[9]  = '{7'h03, 32'h7FF00003, 32'h000007FF, 3'd1, 1'b0};
    tbl[10] = '{7'h67, 32'h80000067, 32'hFFFFF800, 3'd1, 1'b0};
    tbl[11] = '{7'h73, 32'h00100073, 32'h00000001, 3'd1, 1'b0};
    tbl[12] = '{7'h13, 32'h0017F0FF, 32'h00000001, 3'd1, 1'b0};
    tbl[13] = '{7'h7F, 32'h12345013, 32'h00000000, 3'd7, 1'b1};
    tbl[14] = '{7'h23, 32'h7E000FA3, 32'h000007FF, 3'd2, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_imm", imm, 0);
    chk("rst_fmt", fmt_o, 0);
    chk("rst_ill", illegal_o, 0);
    chk("rst_cnt", cnt, 0);
    reset = 1;
    step();
    chk("post_rst_ready", ready_o, 1);
    chk("post_rst_valid", valid_o, 0);

    for (int i = 0; i < 15; i++) begin
      push(tbl[i].op, tbl[i].ins);
      if (tbl[i].ill) exp_cnt++;
      chk($sformatf("v%0d_valid", i), valid_o, 1);
      chk($sformatf("v%0d_imm", i), imm, tbl[i].imm);
      chk($sformatf("v%0d_fmt", i), fmt_o, tbl[i].fmt);
      chk($sformatf("v%0d_ill", i), illegal_o, tbl[i].ill);
      chk($sformatf("v%0d_cnt", i), cnt, exp_cnt);
      step();
      chk($sformatf("v%0d_drained", i), valid_o, 0);
    end

    push(7'h23, 32'hFE112E23);
    chk("sw_zext", z_imm, 64'h00000FFC);
    chk("sw_x64", w_imm, 64'hFFFFFFFFFFFFFFFC);
    step();
    push(7'h63, 32'hFE000CE3);
    chk("beq_zext", z_imm, 64'h00001FF8);
    chk("beq_x64", w_imm, 64'hFFFFFFFFFFFFFFF8);
    step();
    push(7'h17, 32'h80000097);
    chk("auipc_x64", w_imm, 64'hFFFFFFFF80000000);
    chk("auipc_zext", z_imm, 64'h80000000);
    step();

    ready_i = 0;
    valid_i = 1; op_i = 7'h13; inst = 32'h00100093;
    step();
    chk("bp_ready1", ready_o, 1);
    inst = 32'h00200093;
    step();
    chk("bp_ready2", ready_o, 0);
    chk("bp_valid2", valid_o, 1);
    chk("bp_imm2", imm, 1);
    inst = 32'h00300093;
    step();
    chk("bp_hold_ready", ready_o, 0);
    chk("bp_hold_imm", imm, 1);
    ready_i = 1;
    step();
    chk("bp_out2", imm, 2);
    chk("bp_ready3", ready_o, 1);
    step();
    valid_i = 0;
    chk("bp_out3", imm, 3);
    chk("bp_valid3", valid_o, 1);
    step();
    chk("bp_empty", valid_o, 0);

    ready_i = 0;
    valid_i = 1; op_i = 7'h13; inst = 32'h00500093;
    step(); step();
    chk("mr_full", ready_o, 0);
    reset = 0;
    step();
    reset = 1; valid_i = 0; ready_i = 1;
    step();
    chk("mr_valid", valid_o, 0);
    step();
    chk("mr_valid_later", valid_o, 0);
    chk("mr_ready", ready_o, 1);
    exp_cnt = 0;

    valid_i = 1; op_i = 7'h7F; inst = 32'hFFFFFFFF;
    for (int i = 0; i < 300; i++) begin
      step();
      exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
      chk($sformatf("il%0d_ill", i), illegal_o, 1);
      chk($sformatf("il%0d_imm", i), imm, 0);
      chk($sformatf("il%0d_cnt", i), cnt, exp_cnt);
    end
    chk("il_sat", cnt, 8'd255);
    reset = 0;
    step();
    valid_i = 0;
    chk("il_rst_cnt", cnt, 0);
    chk("il_rst_valid", valid_o, 0);
    reset = 1;
    step();
    chk("il_after_valid", valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
